// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with a registered occupancy count,
// programmable almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
// Without it, rdata is a register that loads on every accepted read.
module sync_fifo_prog #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = 2**ASIZE-2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             almost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_C    = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_C    = (ASIZE+1)'(AE_LEVEL);

  logic [DSIZE-1:0] mem_q [DEPTH];

  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic [ASIZE:0] count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;
  logic           wr_ok, rd_ok;

  // Flags come only from the registered count, so winc/rinc never reach them.
  assign wfull        = (count_q == DEPTH_C);
  assign rempty       = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Accept decisions: at full a paired read still goes, at empty a paired write still goes.
  assign wr_ok = winc & ~wfull;
  assign rd_ok = rinc & ~rempty;

  // Next-state for pointers, occupancy and the sticky error flags.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;

    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;

    // A new error in the same cycle as err_clr keeps the flag set.
    if (winc && wfull)  overflow_d = 1'b1;
    else if (err_clr)   overflow_d = 1'b0;

    if (rinc && rempty) underflow_d = 1'b1;
    else if (err_clr)   underflow_d = 1'b0;
  end

  // Control state register; reset discards contents at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array, written on accepted writes only; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q[ASIZE-1:0]] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word falls through; it is meaningless while rempty is high.
  assign rdata = mem_q[rptr_q[ASIZE-1:0]];
`else
  logic [DSIZE-1:0] rdata_q;

  // Registered read data, loaded only on an accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata_q <= '0;
    else if (rd_ok) rdata_q <= mem_q[rptr_q[ASIZE-1:0]];
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Testbench for sync_fifo_prog: directed boundary scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_sync_fifo_prog;

  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 14;
  localparam int AEL   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             winc = 1'b0;
  logic [DSIZE-1:0] wdata = '0;
  logic             wfull;
  logic             almost_full;
  logic             rinc = 1'b0;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             almost_empty;
  logic [ASIZE:0]   count;
  logic             err_clr = 1'b0;
  logic             overflow;
  logic             underflow;

  sync_fifo_prog #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .winc(winc), .wdata(wdata), .wfull(wfull), .almost_full(almost_full),
    .rinc(rinc), .rdata(rdata), .rempty(rempty), .almost_empty(almost_empty),
    .count(count), .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DSIZE-1:0] q[$];
  logic             m_ov;
  logic             m_un;
  logic [DSIZE-1:0] m_rd;
  int               max_seen;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ":count"},  32'(count), 32'(n));
    chk({tag, ":wfull"},  32'(wfull), 32'(n == DEPTH));
    chk({tag, ":rempty"}, 32'(rempty), 32'(n == 0));
    chk({tag, ":afull"},  32'(almost_full), 32'(n >= AFL));
    chk({tag, ":aempty"}, 32'(almost_empty), 32'(n <= AEL));
    chk({tag, ":ovf"},    32'(overflow), 32'(m_ov));
    chk({tag, ":unf"},    32'(underflow), 32'(m_un));
`ifdef SYNC_FIFO_FWFT_EN
    if (n > 0) chk({tag, ":rdata"}, 32'(rdata), 32'(q[0]));
`else
    chk({tag, ":rdata"}, 32'(rdata), 32'(m_rd));
`endif
  endtask

  // One clock cycle of stimulus; model advances by the FIFO's stated rules.
  task automatic step(input string tag, input logic w, input logic [DSIZE-1:0] d,
                      input logic r, input logic clr);
    bit full, empty, w_acc, r_acc;
    @(negedge clk);
    winc = w; wdata = d; rinc = r; err_clr = clr;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    w_acc = w && !full;
    r_acc = r && !empty;
    if (r_acc) m_rd = q.pop_front();
    if (w_acc) q.push_back(d);
    if (w && full)      m_ov = 1'b1;
    else if (clr)       m_ov = 1'b0;
    if (r && empty)     m_un = 1'b1;
    else if (clr)       m_un = 1'b0;
    if (q.size() > max_seen) max_seen = q.size();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0; m_un = 1'b0; m_rd = '0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    model_reset();
    max_seen = 0;

    // Reset state
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 0x01..0x10, then a 17th write overflows
    for (int i = 1; i <= 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    step("fill17", 1'b1, 8'h11, 1'b0, 1'b0);

    // Drain 16 words, then a 17th read underflows
    for (int i = 1; i <= 16; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    step("drain17", 1'b0, '0, 1'b1, 1'b0);

    // err_clr clears both sticky flags
    step("errclr", 1'b0, '0, 1'b0, 1'b1);

    // Wrap: push 10, pop 10, then 20 interleaved push/pop
    for (int i = 0; i < 10; i++) step("wrap_push", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("wrap_pop", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step("wrap_ipush", 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
      step("wrap_ipop", 1'b0, '0, 1'b1, 1'b0);
    end
    chk("wrap_max", 32'(max_seen), 32'(DEPTH));

    // Simultaneous at full: read wins, overflow sets
    for (int i = 0; i < 16; i++) step("sfill", 1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    step("sim_full", 1'b1, 8'hEE, 1'b1, 1'b0);
    chk("sim_full_cnt", 32'(count), 32'd15);

    // Simultaneous at empty: write wins, underflow sets, 0xA5 read next
    while (q.size() > 0) step("sdrain", 1'b0, '0, 1'b1, 1'b0);
    step("clr2", 1'b0, '0, 1'b0, 1'b1);
    step("sim_empty", 1'b1, 8'hA5, 1'b1, 1'b0);
    chk("sim_empty_cnt", 32'(count), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("sim_empty_head", 32'(rdata), 32'hA5);
`endif
    step("read_a5", 1'b0, '0, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("read_a5_val", 32'(rdata), 32'hA5);
`endif

    // Simultaneous at count 8
    for (int i = 0; i < 8; i++) step("mfill", 1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    step("sim_mid", 1'b1, 8'hBB, 1'b1, 1'b0);
    chk("sim_mid_cnt", 32'(count), 32'd8);

    // err_clr coincident with a write at full keeps overflow
    for (int i = 0; i < 8; i++) step("efill", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step("ovf_set", 1'b1, 8'hFF, 1'b0, 1'b0);
    step("clr_vs_ovf", 1'b1, 8'hFE, 1'b0, 1'b1);
    chk("clr_vs_ovf_flag", 32'(overflow), 32'd1);
    step("clr3", 1'b0, '0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 99));
      step("rand", k < 55, 8'($urandom), (k % 3) != 0 && k > 25, ($urandom_range(0, 31) == 0));
    end

    // Mid-operation reset with count=9, between clock edges
    while (q.size() > 0) step("pre_rst_drain", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step("pre_rst_fill", 1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
    step("pre_rst_rd", 1'b0, '0, 1'b1, 1'b0);
    step("pre_rst_wr", 1'b1, 8'hDD, 1'b0, 1'b0);
    step("pre_rst_unf", 1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_cnt", 32'(count), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_wr", 1'b1, 8'h3C, 1'b0, 1'b0);
    step("post_rst_rd", 1'b0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
